pingpong_buffer: RTL and testbench



---
 rtl/pingpong_buffer.sv | 141 ++++++++++++++
 tb/tb_pingpong_buffer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pingpong_buffer.sv
// Double-buffered frame store: the writer fills one bank while the reader drains the other.
// A frame only becomes readable once all FRAME_LEN words have landed in its bank.
module pingpong_buffer #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 10,
    parameter int FRAME_LEN = 1024
) (
    input  logic              iclk,
    input  logic              irst_n,
    input  logic              ivalid,
    input  logic [DATA_W-1:0] idata,
    input  logic              isof,
    output logic              owr_ready,
    input  logic              iready,
    output logic              ovalid,
    output logic [DATA_W-1:0] odata,
    output logic              osof,
    output logic              oeof,
    output logic              ooverflow,
    output logic              oframe_err
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_LEN - 1);

    generate
        if (FRAME_LEN < 2 || FRAME_LEN > DEPTH) begin : g_bad_frame_len
            $error("pingpong_buffer: FRAME_LEN must lie in 2 .. 2**ADDR_W");
        end
    endgenerate

    typedef enum logic [1:0] {FREE, FILLING, FULL, DRAINING} bank_st_t;

    bank_st_t          r_st [2];
    bank_st_t          w_st_nxt [2];
    logic              r_wr_bank;
    logic              r_rd_bank;
    logic [ADDR_W-1:0] r_wr_idx;
    logic [ADDR_W-1:0] r_rd_idx;
    logic              r_wr_ready;
    logic              r_ovalid;
    logic [DATA_W-1:0] r_odata;
    logic              r_osof;
    logic              r_oeof;
    logic              r_ovf;
    logic              r_ferr;
    logic [DATA_W-1:0] r_mem0 [DEPTH];
    logic [DATA_W-1:0] r_mem1 [DEPTH];

    logic              w_wr_en;
    logic              w_restart;
    logic [ADDR_W-1:0] w_wr_addr;
    logic              w_wr_last;
    logic              w_wr_bank_nxt;
    logic              w_rd_issue;
    logic              w_rd_last;
    logic              w_ready_nxt;
    logic [DATA_W-1:0] w_rd_word;

    // An early start-of-frame throws away the partial frame by rewinding to index 0.
    assign w_wr_en       = ivalid & r_wr_ready;
    assign w_restart     = w_wr_en & isof & (r_wr_idx != '0);
    assign w_wr_addr     = w_restart ? '0 : r_wr_idx;
    assign w_wr_last     = w_wr_en & (w_wr_addr == LAST_IDX);
    assign w_wr_bank_nxt = r_wr_bank ^ w_wr_last;

    assign w_rd_issue = ((r_st[r_rd_bank] == FULL) || (r_st[r_rd_bank] == DRAINING))
                        && (!r_ovalid || iready);
    assign w_rd_last  = w_rd_issue & (r_rd_idx == LAST_IDX);
    assign w_rd_word  = r_rd_bank ? r_mem1[r_rd_idx] : r_mem0[r_rd_idx];

    always_comb begin
        w_st_nxt[0] = r_st[0];
        w_st_nxt[1] = r_st[1];
        for (int b = 0; b < 2; b++) begin
            if (w_wr_en && (r_wr_bank == 1'(b)))
                w_st_nxt[b] = w_wr_last ? FULL : FILLING;
            if (w_rd_issue && (r_rd_bank == 1'(b)))
                w_st_nxt[b] = w_rd_last ? FREE : DRAINING;
        end
    end

    // Ready is judged on next-cycle state so a bank freed this cycle is usable at once.
    assign w_ready_nxt = (w_st_nxt[w_wr_bank_nxt] == FREE) ||
                         (w_st_nxt[w_wr_bank_nxt] == FILLING);

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            r_st[0]    <= FREE;
            r_st[1]    <= FREE;
            r_wr_bank  <= 1'b0;
            r_rd_bank  <= 1'b0;
            r_wr_idx   <= '0;
            r_rd_idx   <= '0;
            r_wr_ready <= 1'b1;
            r_ovalid   <= 1'b0;
            r_odata    <= '0;
            r_osof     <= 1'b0;
            r_oeof     <= 1'b0;
            r_ovf      <= 1'b0;
            r_ferr     <= 1'b0;
        end else begin
            r_st[0]    <= w_st_nxt[0];
            r_st[1]    <= w_st_nxt[1];
            r_wr_bank  <= w_wr_bank_nxt;
            r_rd_bank  <= r_rd_bank ^ w_rd_last;
            r_wr_ready <= w_ready_nxt;
            r_ovalid   <= w_rd_issue | (r_ovalid & ~iready);
            r_ovf      <= r_ovf | (ivalid & ~r_wr_ready);
            r_ferr     <= w_restart;
            if (w_wr_en)
                r_wr_idx <= w_wr_last ? '0 : w_wr_addr + ADDR_W'(1);
            if (w_rd_issue) begin
                r_rd_idx <= w_rd_last ? '0 : r_rd_idx + ADDR_W'(1);
                r_odata  <= w_rd_word;
                r_osof   <= (r_rd_idx == '0);
                r_oeof   <= (r_rd_idx == LAST_IDX);
            end
        end
    end

    always_ff @(posedge iclk) begin
        if (w_wr_en && !r_wr_bank)
            r_mem0[w_wr_addr] <= idata;
        if (w_wr_en && r_wr_bank)
            r_mem1[w_wr_addr] <= idata;
    end

    // Writer only touches FREE/FILLING banks, reader only FULL/DRAINING ones.
    a_no_bank_clash : assert property (@(posedge iclk) disable iff (!irst_n)
        !(w_wr_en && w_rd_issue && (r_wr_bank == r_rd_bank)));

    assign owr_ready  = r_wr_ready;
    assign ovalid     = r_ovalid;
    assign odata      = r_odata;
    assign osof       = r_osof;
    assign oeof       = r_oeof;
    assign ooverflow  = r_ovf;
    assign oframe_err = r_ferr;

endmodule

// File: tb/tb_pingpong_buffer.sv
// Scoreboard bench for pingpong_buffer with 4-word frames and 8-word banks.
module tb_pingpong_buffer;

    localparam int DW = 16;
    localparam int AW = 3;
    localparam int FL = 4;

    logic          iclk   = 1'b0;
    logic          irst_n = 1'b1;
    logic          ivalid = 1'b0;
    logic [DW-1:0] idata  = '0;
    logic          isof   = 1'b0;
    logic          iready = 1'b0;
    logic          owr_ready;
    logic          ovalid;
    logic [DW-1:0] odata;
    logic          osof;
    logic          oeof;
    logic          ooverflow;
    logic          oframe_err;

    pingpong_buffer #(.DATA_W(DW), .ADDR_W(AW), .FRAME_LEN(FL)) dut (
        .iclk       (iclk),
        .irst_n     (irst_n),
        .ivalid     (ivalid),
        .idata      (idata),
        .isof       (isof),
        .owr_ready  (owr_ready),
        .iready     (iready),
        .ovalid     (ovalid),
        .odata      (odata),
        .osof       (osof),
        .oeof       (oeof),
        .ooverflow  (ooverflow),
        .oframe_err (oframe_err)
    );

    always #5 iclk = ~iclk;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          sof;
        logic          eof;
    } exp_t;

    exp_t exp_q [$];
    exp_t mon_e;
    int   n_checks  = 0;
    int   n_err     = 0;
    int   cyc_cnt   = 0;
    int   first_acc = -1;
    int   last_acc  = -1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    initial forever begin
        @(posedge iclk);
        cyc_cnt++;
    end

    // Monitor: every accepted output word is popped and compared against the model.
    initial forever begin
        @(negedge iclk);
        if (irst_n && ovalid && iready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL out_extra: got word 0x%0h, expected no output", odata);
            end else begin
                mon_e = exp_q.pop_front();
                chk("out_word", 32'({odata, osof, oeof}), 32'({mon_e.d, mon_e.sof, mon_e.eof}));
            end
            if (first_acc < 0) first_acc = cyc_cnt;
            last_acc = cyc_cnt;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge iclk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] d, input logic s, input logic e);
        exp_t x;
        x.d = d; x.sof = s; x.eof = e;
        exp_q.push_back(x);
    endtask

    task automatic push_frame(input logic [DW-1:0] base);
        for (int i = 0; i < FL; i++)
            push(base + DW'(i), i == 0, i == FL - 1);
    endtask

    task automatic write_frame(input logic [DW-1:0] base);
        for (int i = 0; i < FL; i++) begin
            ivalid = 1'b1;
            idata  = base + DW'(i);
            isof   = (i == 0);
            cyc();
        end
        ivalid = 1'b0;
        isof   = 1'b0;
    endtask

    task automatic wait_drain(input string nm);
        int k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            cyc();
            k++;
        end
        chk(nm, 32'(exp_q.size()), 32'd0);
        cyc();
        cyc();
    endtask

    task automatic do_reset();
        irst_n = 1'b0;
        #1;
        chk("rst_ovalid",    32'(ovalid),     32'd0);
        chk("rst_odata",     32'(odata),      32'd0);
        chk("rst_osof",      32'(osof),       32'd0);
        chk("rst_oeof",      32'(oeof),       32'd0);
        chk("rst_overflow",  32'(ooverflow),  32'd0);
        chk("rst_frame_err", 32'(oframe_err), 32'd0);
        chk("rst_wr_ready",  32'(owr_ready),  32'd1);
        exp_q.delete();
        ivalid = 1'b0;
        isof   = 1'b0;
        repeat (2) @(posedge iclk);
        #1;
        irst_n = 1'b1;
    endtask

    initial begin
        int drops;
        int fe;
        int k;
        logic found;

        #2;
        do_reset();

        // Basic frame: first ovalid two cycles after the last word.
        iready = 1'b1;
        push_frame(16'd1);
        write_frame(16'd1);
        chk("lat_not_yet", 32'(ovalid), 32'd0);
        cyc();
        chk("lat_first_valid", 32'(ovalid), 32'd1);
        wait_drain("basic_drain");

        // Streaming: 8 frames back to back.
        first_acc = -1;
        drops = 0;
        for (int f = 1; f <= 8; f++) push_frame(DW'(16'h100 * f));
        for (int w = 0; w < 8 * FL; w++) begin
            if (!owr_ready) drops++;
            ivalid = 1'b1;
            idata  = DW'(16'h100 * (w / FL + 1) + (w % FL));
            isof   = (w % FL == 0);
            cyc();
        end
        ivalid = 1'b0;
        isof   = 1'b0;
        wait_drain("stream_drain");
        chk("stream_ready_drops", 32'(drops), 32'd0);
        chk("stream_span", 32'(last_acc - first_acc + 1), 32'd32);
        chk("stream_overflow", 32'(ooverflow), 32'd0);

        // Backpressure: reader stalls 10 cycles while the writer keeps going.
        for (int f = 0; f < 3; f++) push_frame(DW'(16'h200 + 16'h100 * f));
        fork
            begin
                int w = 0;
                int lowc = 0;
                int kk = 0;
                while (w < 3 * FL && kk < 300) begin
                    if (owr_ready) begin
                        ivalid = 1'b1;
                        idata  = DW'(16'h200 + 16'h100 * (w / FL) + (w % FL));
                        isof   = (w % FL == 0);
                        w++;
                    end else begin
                        ivalid = 1'b0;
                        isof   = 1'b0;
                        lowc++;
                    end
                    cyc();
                    kk++;
                end
                ivalid = 1'b0;
                isof   = 1'b0;
                chk("bp_ready_fell", 32'(lowc > 0), 32'd1);
                chk("bp_all_written", 32'(w), 32'd12);
            end
            begin
                int kk = 0;
                while (!ovalid && kk < 50) begin
                    cyc();
                    kk++;
                end
                iready = 1'b0;
                repeat (10) begin
                    @(negedge iclk);
                    chk("bp_hold_valid", 32'(ovalid), 32'd1);
                    chk("bp_hold_data", 32'(odata), 32'(exp_q[0].d));
                end
                cyc();
                iready = 1'b1;
            end
        join
        wait_drain("bp_drain");
        chk("bp_overflow", 32'(ooverflow), 32'd0);

        // Overflow: both banks occupied, 0xDEAD offered and dropped.
        iready = 1'b0;
        push_frame(16'h500);
        push_frame(16'h600);
        write_frame(16'h500);
        write_frame(16'h600);
        chk("ovf_ready_low", 32'(owr_ready), 32'd0);
        chk("ovf_flag_before", 32'(ooverflow), 32'd0);
        ivalid = 1'b1;
        idata  = 16'hDEAD;
        cyc();
        ivalid = 1'b0;
        chk("ovf_flag_set", 32'(ooverflow), 32'd1);
        iready = 1'b1;
        wait_drain("ovf_drain");
        chk("ovf_flag_sticky", 32'(ooverflow), 32'd1);
        do_reset();

        // Early start-of-frame: 1,2 discarded, frame restarts with 9.
        iready = 1'b1;
        push(16'd9, 1'b1, 1'b0);
        push(16'd10, 1'b0, 1'b0);
        push(16'd11, 1'b0, 1'b0);
        push(16'd12, 1'b0, 1'b1);
        fe = 0;
        for (int i = 0; i < 9; i++) begin
            ivalid = (i < 6);
            case (i)
                0: begin idata = 16'd1;  isof = 1'b1; end
                1: begin idata = 16'd2;  isof = 1'b0; end
                2: begin idata = 16'd9;  isof = 1'b1; end
                3: begin idata = 16'd10; isof = 1'b0; end
                4: begin idata = 16'd11; isof = 1'b0; end
                5: begin idata = 16'd12; isof = 1'b0; end
                default: begin idata = '0; isof = 1'b0; end
            endcase
            cyc();
            if (oframe_err) fe++;
        end
        chk("sof_err_pulses", 32'(fe), 32'd1);
        wait_drain("sof_drain");

        // Reset while the second output word is on the bus.
        push_frame(16'h50);
        write_frame(16'h50);
        ivalid = 1'b1; idata = 16'h60; isof = 1'b1;
        cyc();
        idata = 16'h61; isof = 1'b0;
        cyc();
        ivalid = 1'b0;
        k = 0;
        found = 1'b0;
        while (k < 20 && !found) begin
            if (ovalid && odata == 16'h51) found = 1'b1;
            else begin
                cyc();
                k++;
            end
        end
        chk("rst_word2_seen", 32'(found), 32'd1);
        do_reset();
        push_frame(16'h70);
        write_frame(16'h70);
        wait_drain("rst_after_drain");
        chk("rst_after_idle", 32'(ovalid), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
